// File: rtl/one_to_n_demux_pkg.sv
// Shared lane/select definitions and lock-state encoding for the 1-to-3 stream demux.
package one_to_n_pkg;

  localparam int NUM_LANES = 3;
  localparam int SEL_W     = 2;

  typedef logic [SEL_W-1:0] sel_t;

  localparam sel_t SEL_NULL = 2'd3;

  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } lock_state_t;

  function automatic logic is_null_sel(sel_t s);
    return s == SEL_NULL;
  endfunction

endpackage

// File: rtl/one_to_n_demux_if.sv
// Producer-side input stream plus three per-lane output streams; master = producer/consumers, slave = demux.
interface one_to_n_demux_if
  import one_to_n_pkg::*;
#(
  parameter int WIDTH = 8
);

  logic             in_val;
  logic [WIDTH-1:0] in_data;
  sel_t             in_sel;
  logic             in_last;
  logic             in_rdy;

  logic             out0_val;
  logic [WIDTH-1:0] out0_data;
  logic             out0_last;
  logic             out0_rdy;

  logic             out1_val;
  logic [WIDTH-1:0] out1_data;
  logic             out1_last;
  logic             out1_rdy;

  logic             out2_val;
  logic [WIDTH-1:0] out2_data;
  logic             out2_last;
  logic             out2_rdy;

  modport master (
    output in_val, in_data, in_sel, in_last,
    input  in_rdy,
    input  out0_val, out0_data, out0_last,
    output out0_rdy,
    input  out1_val, out1_data, out1_last,
    output out1_rdy,
    input  out2_val, out2_data, out2_last,
    output out2_rdy
  );

  modport slave (
    input  in_val, in_data, in_sel, in_last,
    output in_rdy,
    output out0_val, out0_data, out0_last,
    input  out0_rdy,
    output out1_val, out1_data, out1_last,
    input  out1_rdy,
    output out2_val, out2_data, out2_last,
    input  out2_rdy
  );

endinterface

// File: rtl/one_to_n_demux_lane_reg.sv
// One-entry val/data/last output register, latency 1; loads while draining for full rate,
// holds contents stable while val & !rdy.
module demux_lane_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             last_i,
  input  logic             rdy_i,
  output logic             val_o,
  output logic [WIDTH-1:0] data_o,
  output logic             last_o
);

  logic             val_q,  val_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             last_q, last_d;

  always_comb begin
    val_d  = val_q;
    data_d = data_q;
    last_d = last_q;
    if (load_i) begin
      val_d  = 1'b1;
      data_d = data_i;
      last_d = last_i;
    end else if (val_q && rdy_i) begin
      val_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val_q  <= 1'b0;
      data_q <= '0;
      last_q <= 1'b0;
    end else begin
      val_q  <= val_d;
      data_q <= data_d;
      last_q <= last_d;
    end
  end

  assign val_o  = val_q;
  assign data_o = data_q;
  assign last_o = last_q;

endmodule

// File: rtl/one_to_n_demux.sv
// Registered 1-to-3 stream demux with per-packet route lock; latency 1, in_rdy follows only the selected lane.
// ONE_TO_N_DEMUX_STATS_EN adds 16-bit per-lane and drop beat counters.
module one_to_n_demux
  import one_to_n_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  one_to_n_demux_if.slave    bus
`ifdef ONE_TO_N_DEMUX_STATS_EN
  ,
  output logic [15:0]        stat0,
  output logic [15:0]        stat1,
  output logic [15:0]        stat2,
  output logic [15:0]        stat_drop
`endif
);

  lock_state_t state_q, state_d;
  sel_t        lock_sel_q, lock_sel_d;
  sel_t        esel;
  logic        lane_free;
  logic        accept;

  logic [NUM_LANES-1:0] lane_val;
  logic [NUM_LANES-1:0] lane_rdy;
  logic [NUM_LANES-1:0] lane_load;
  logic [NUM_LANES-1:0] lane_last;
  logic [WIDTH-1:0]     lane_data [NUM_LANES];

  assign lane_rdy = {bus.out2_rdy, bus.out1_rdy, bus.out0_rdy};

  // The null select has no lane register, so it is always free.
  always_comb begin
    esel      = (state_q == ST_LOCKED) ? lock_sel_q : bus.in_sel;
    lane_free = 1'b1;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (esel == sel_t'(i)) begin
        lane_free = !lane_val[i] || lane_rdy[i];
      end
    end
  end

  assign bus.in_rdy = !rst && lane_free;
  assign accept     = bus.in_val && bus.in_rdy;

  always_comb begin
    state_d    = state_q;
    lock_sel_d = lock_sel_q;
    unique case (state_q)
      ST_UNLOCKED: begin
        if (accept && !bus.in_last) begin
          state_d    = ST_LOCKED;
          lock_sel_d = bus.in_sel;
        end
      end
      ST_LOCKED: begin
        if (accept && bus.in_last) begin
          state_d = ST_UNLOCKED;
        end
      end
      default: state_d = ST_UNLOCKED;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_UNLOCKED;
      lock_sel_q <= '0;
    end else begin
      state_q    <= state_d;
      lock_sel_q <= lock_sel_d;
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign lane_load[g] = accept && (esel == sel_t'(g));

    demux_lane_reg #(
      .WIDTH (WIDTH)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .load_i (lane_load[g]),
      .data_i (bus.in_data),
      .last_i (bus.in_last),
      .rdy_i  (lane_rdy[g]),
      .val_o  (lane_val[g]),
      .data_o (lane_data[g]),
      .last_o (lane_last[g])
    );
  end

  assign bus.out0_val  = lane_val[0];
  assign bus.out0_data = lane_data[0];
  assign bus.out0_last = lane_last[0];
  assign bus.out1_val  = lane_val[1];
  assign bus.out1_data = lane_data[1];
  assign bus.out1_last = lane_last[1];
  assign bus.out2_val  = lane_val[2];
  assign bus.out2_data = lane_data[2];
  assign bus.out2_last = lane_last[2];

`ifdef ONE_TO_N_DEMUX_STATS_EN
  logic [15:0] stat_q [NUM_LANES];
  logic [15:0] stat_drop_q;
  logic        drop;

  assign drop = accept && is_null_sel(esel);

  // Counters wrap naturally at 16 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        stat_q[i] <= '0;
      end
      stat_drop_q <= '0;
    end else begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (lane_load[i]) begin
          stat_q[i] <= stat_q[i] + 16'd1;
        end
      end
      if (drop) begin
        stat_drop_q <= stat_drop_q + 16'd1;
      end
    end
  end

  assign stat0     = stat_q[0];
  assign stat1     = stat_q[1];
  assign stat2     = stat_q[2];
  assign stat_drop = stat_drop_q;
`endif

endmodule
